// File: rtl/enum_packer_pkg.sv
// Shared types for the enum packer: element encoding, FSM state types and
// the counter width helper.
package enum_packer_pkg;

    localparam int ELEM_WIDTH_DEF = 1;
    localparam int COUNT_DEF      = 2;

    // Element encoding; must stay identical to what the downstream cast
    // stage expects for EnumA/EnumB.
    typedef enum logic [0:0] {
        ELEM_A = 1'b0,
        ELEM_B = 1'b1
    } elem_e;

    typedef enum logic {
        ACC_EMPTY = 1'b0,
        ACC_FILL  = 1'b1
    } acc_state_e;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_HOLD = 1'b1
    } out_state_e;

    // Counters must be able to represent COUNT itself (o_count reaches COUNT).
    function automatic int cnt_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/enum_packer_out_reg.sv
// Output holding register for the enum packer. Holds one packed word and
// presents it with a valid/ready handshake towards the cast stage.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   OUT_IDLE | no word pending; data/count keep the last word sent
//   OUT_HOLD | word pending on data_o/count_o until ready_i is seen
module enum_packer_out_reg
    import enum_packer_pkg::*;
#(
    parameter int WORD_W    = 2,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 load_i,
    input  logic [WORD_W-1:0]    word_i,
    input  logic [CNT_WIDTH-1:0] count_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [WORD_W-1:0]    data_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 ready_o
);

    out_state_e           state_q, state_d;
    logic [WORD_W-1:0]    data_q, data_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Next state and register load; a load always wins over a drain so that
    // a transfer and a new word in the same cycle stay in OUT_HOLD.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        unique case (state_q)
            OUT_IDLE: begin
                if (load_i) begin
                    state_d = OUT_HOLD;
                    data_d  = word_i;
                    count_d = count_i;
                end
            end
            OUT_HOLD: begin
                if (load_i) begin
                    data_d  = word_i;
                    count_d = count_i;
                end else if (ready_i) begin
                    state_d = OUT_IDLE;
                end
            end
            default: state_d = OUT_IDLE;
        endcase
    end

    // State and holding register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= OUT_IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (state_q == OUT_HOLD);
    assign data_o  = data_q;
    assign count_o = count_q;
    // Upstream may only push while this slot is free or being drained.
    assign ready_o = !valid_o || ready_i;

    // A new word can only arrive when the slot can take it.
    a_load_when_ready: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) load_i |-> ready_o);

    // A stalled word must not change under the consumer.
    a_hold_stable: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(count_o)));

endmodule

// File: rtl/enum_packer.sv
// Enum packer: collects COUNT narrow enum elements into one word for the
// enum-cast stage. A last-marker closes a partial word, zero-padded.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ACC_EMPTY | accumulator empty, acc_cnt == 0
//   ACC_FILL  | partial word held, 0 < acc_cnt < COUNT
module enum_packer
    import enum_packer_pkg::*;
#(
    parameter  int ELEM_WIDTH = ELEM_WIDTH_DEF,
    parameter  int COUNT      = COUNT_DEF,
    localparam int CNT_WIDTH  = cnt_width(COUNT)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [ELEM_WIDTH-1:0]       i_data,
    input  logic                        i_last,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [ELEM_WIDTH*COUNT-1:0] o_data,
    output logic [CNT_WIDTH-1:0]        o_count
);

    localparam int                   WORD_W    = ELEM_WIDTH * COUNT;
    localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(COUNT - 1);

    acc_state_e           acc_state_q, acc_state_d;
    logic [WORD_W-1:0]    acc_q, acc_d;
    logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;

    logic                 out_ready;
    logic                 accept;
    logic                 completing;
    logic [WORD_W-1:0]    merged;
    logic [CNT_WIDTH-1:0] merged_cnt;

    assign accept     = i_valid && out_ready;
    assign completing = accept && (i_last || (acc_cnt_q == LAST_SLOT));
    assign merged_cnt = acc_cnt_q + CNT_WIDTH'(1);
    assign o_ready    = out_ready;

    // Current accumulator with the incoming element dropped into slot
    // acc_cnt; slots above it are still zero, which gives the padding.
    always_comb begin
        merged = acc_q;
        for (int k = 0; k < COUNT; k++) begin
            if (acc_cnt_q == CNT_WIDTH'(k)) begin
                merged[k*ELEM_WIDTH +: ELEM_WIDTH] = i_data;
            end
        end
    end

    // Accumulator next state: fill on plain beats, empty on a completing beat.
    always_comb begin
        acc_state_d = acc_state_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        unique case (acc_state_q)
            ACC_EMPTY, ACC_FILL: begin
                if (completing) begin
                    acc_state_d = ACC_EMPTY;
                    acc_d       = '0;
                    acc_cnt_d   = '0;
                end else if (accept) begin
                    acc_state_d = ACC_FILL;
                    acc_d       = merged;
                    acc_cnt_d   = merged_cnt;
                end
            end
            default: begin
                acc_state_d = ACC_EMPTY;
                acc_d       = '0;
                acc_cnt_d   = '0;
            end
        endcase
    end

    // Accumulator registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_state_q <= ACC_EMPTY;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
        end else begin
            acc_state_q <= acc_state_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    enum_packer_out_reg #(
        .WORD_W    (WORD_W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_out_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load_i  (completing),
        .word_i  (merged),
        .count_i (merged_cnt),
        .ready_i (i_ready),
        .valid_o (o_valid),
        .data_o  (o_data),
        .count_o (o_count),
        .ready_o (out_ready)
    );

    // The slot index never reaches COUNT; a completing beat resets it first.
    a_cnt_range: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) acc_cnt_q <= LAST_SLOT);

    // State and count must agree on emptiness.
    a_state_cnt: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (acc_state_q == ACC_EMPTY) == (acc_cnt_q == '0));

endmodule

// File: tb/tb_enum_packer.sv
module tb_enum_packer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ELEM_WIDTH=1, COUNT=2
    logic       a_valid = 1'b0, a_last = 1'b0, a_iready = 1'b0;
    logic [0:0] a_data = '0;
    logic       a_ready, a_ovalid;
    logic [1:0] a_odata;
    logic [1:0] a_ocount;

    // Instance B: ELEM_WIDTH=2, COUNT=4
    logic       b_valid = 1'b0, b_last = 1'b0, b_iready = 1'b0;
    logic [1:0] b_data = '0;
    logic       b_ready, b_ovalid;
    logic [7:0] b_odata;
    logic [2:0] b_ocount;

    enum_packer #(.ELEM_WIDTH(1), .COUNT(2)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready),
        .i_data(a_data), .i_last(a_last), .o_valid(a_ovalid), .i_ready(a_iready),
        .o_data(a_odata), .o_count(a_ocount));

    enum_packer #(.ELEM_WIDTH(2), .COUNT(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
        .i_data(b_data), .i_last(b_last), .o_valid(b_ovalid), .i_ready(b_iready),
        .o_data(b_odata), .o_count(b_ocount));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: element list -> words, one pending output word.
    bit          m_valid [2];
    int unsigned m_data  [2];
    int unsigned m_count [2];
    int unsigned acc_word[2];
    int unsigned acc_n   [2];

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_data[k] = 0; m_count[k] = 0;
            acc_word[k] = 0; acc_n[k] = 0;
        end
    endfunction

    function automatic void model_step(int k, bit v, bit r, int unsigned d, bit l);
        int unsigned ew, cn;
        bit take, done;
        ew   = (k == 0) ? 1 : 2;
        cn   = (k == 0) ? 2 : 4;
        take = v && (!m_valid[k] || r);
        done = take && (l || (acc_n[k] + 1 == cn));
        if (take) begin
            acc_word[k] = acc_word[k] | (d << (acc_n[k] * ew));
            acc_n[k]    = acc_n[k] + 1;
        end
        if (done) begin
            m_valid[k]  = 1'b1;
            m_data[k]   = acc_word[k];
            m_count[k]  = acc_n[k];
            acc_word[k] = 0;
            acc_n[k]    = 0;
        end else if (m_valid[k] && r) begin
            m_valid[k] = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_clear();
        else begin
            model_step(0, a_valid, a_iready, a_data, a_last);
            model_step(1, b_valid, b_iready, b_data, b_last);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("a_valid", a_ovalid, m_valid[0]);
        chk("a_ready", a_ready,  !m_valid[0] || a_iready);
        chk("a_data",  a_odata,  m_data[0]);
        chk("a_count", a_ocount, m_count[0]);
        chk("b_valid", b_ovalid, m_valid[1]);
        chk("b_ready", b_ready,  !m_valid[1] || b_iready);
        chk("b_data",  b_odata,  m_data[1]);
        chk("b_count", b_ocount, m_count[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pat [8] = '{1, 1, 0, 1, 0, 0, 1, 0};
    int wrd [4] = '{3, 2, 0, 1};

    initial begin
        model_clear();
        repeat (2) tick();
        chk("rst_a_valid", a_ovalid, 0);
        chk("rst_a_data",  a_odata,  0);
        chk("rst_a_count", a_ocount, 0);
        chk("rst_b_valid", b_ovalid, 0);
        rst_n = 1'b1;
        tick();

        // Two plain beats complete a full word.
        a_iready = 1'b1; a_valid = 1'b1; a_data = 1'b1; a_last = 1'b0;
        chk("t1_ready0", a_ready, 1);
        tick();
        a_data = 1'b0;
        chk("t1_ready1", a_ready, 1);
        tick();
        a_valid = 1'b0;
        chk("t1_valid", a_ovalid, 1);
        chk("t1_data",  a_odata,  2'b01);
        chk("t1_count", a_ocount, 2);
        chk("t1_ready2", a_ready, 1);

        // Single-element words, twice, no stale bits.
        repeat (2) begin
            a_valid = 1'b1; a_data = 1'b1; a_last = 1'b1;
            tick();
            a_valid = 1'b0; a_last = 1'b0;
            chk("t2_data",  a_odata,  2'b01);
            chk("t2_count", a_ocount, 1);
        end

        // Backpressure on word 2'b10.
        tick();
        chk("t3_drained", a_ovalid, 0);
        a_iready = 1'b0; a_valid = 1'b1; a_data = 1'b0;
        tick();
        a_data = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", a_ovalid, 1);
            chk("t3_hold_data",  a_odata,  2'b10);
            chk("t3_hold_count", a_ocount, 2);
            chk("t3_hold_ready", a_ready,  0);
            tick();
        end
        a_valid = 1'b0; a_iready = 1'b1;
        #1;
        chk("t3_ready_rise", a_ready, 1);
        tick();
        chk("t3_xfer", a_ovalid, 0);

        // Streaming, one element per cycle.
        a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_data = pat[i][0:0];
            chk("t4_ready", a_ready, 1);
            tick();
            if (i % 2 == 1) begin
                chk("t4_valid", a_ovalid, 1);
                chk("t4_data",  a_odata,  wrd[i/2]);
            end
        end
        a_valid = 1'b0;
        tick();

        // Wide elements, partial word closed by last.
        b_iready = 1'b1; b_valid = 1'b1; b_data = 2'd3;
        tick();
        b_data = 2'd1;
        tick();
        b_data = 2'd2; b_last = 1'b1;
        tick();
        b_valid = 1'b0; b_last = 1'b0;
        chk("t5_data",  b_odata,  8'b00_10_01_11);
        chk("t5_count", b_ocount, 3);
        tick();

        // Reset mid-word discards the partial element.
        a_valid = 1'b1; a_data = 1'b1;
        tick();
        a_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", a_ovalid, 0);
        chk("t6_rst_data",  a_odata,  0);
        chk("t6_rst_count", a_ocount, 0);
        tick();
        tick();
        rst_n = 1'b1;
        a_valid = 1'b1; a_data = 1'b0;
        tick();
        chk("t6_post_valid", a_ovalid, 0);
        a_data = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("t6_data",  a_odata,  2'b10);
        chk("t6_count", a_ocount, 2);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            a_valid  = ($urandom_range(0, 3) != 0);
            a_data   = 1'($urandom_range(0, 1));
            a_last   = ($urandom_range(0, 4) == 0);
            a_iready = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            b_valid  = ($urandom_range(0, 3) != 0);
            b_data   = 2'($urandom_range(0, 3));
            b_last   = ($urandom_range(0, 5) == 0);
            b_iready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
